// File: rtl/falu_arbiter.sv
// falu_arbiter: round-robin two-port arbiter/sequencer in front of the shared FALU.
// Optional response timeout is compiled in when FALU_ARB_TIMEOUT_EN is defined.
module falu_arbiter #(
  parameter int TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset,

  input  logic             io_req0_valid,
  output logic             io_req0_ready,
  input  logic [31:0]      io_req0_input1,
  input  logic [31:0]      io_req0_input2,
  input  logic [3:0]       io_req0_aluCtl,
  input  logic [2:0]       io_req0_rmm,
  input  logic [TAG_W-1:0] io_req0_tag,

  input  logic             io_req1_valid,
  output logic             io_req1_ready,
  input  logic [31:0]      io_req1_input1,
  input  logic [31:0]      io_req1_input2,
  input  logic [3:0]       io_req1_aluCtl,
  input  logic [2:0]       io_req1_rmm,
  input  logic [TAG_W-1:0] io_req1_tag,

  output logic             io_resp0_valid,
  input  logic             io_resp0_ready,
  output logic [31:0]      io_resp0_result,
  output logic [TAG_W-1:0] io_resp0_tag,

  output logic             io_resp1_valid,
  input  logic             io_resp1_ready,
  output logic [31:0]      io_resp1_result,
  output logic [TAG_W-1:0] io_resp1_tag,

  output logic [31:0]      io_falu_input1,
  output logic [31:0]      io_falu_input2,
  output logic [3:0]       io_falu_aluCtl,
  output logic [2:0]       io_falu_rmm,
  input  logic [31:0]      io_falu_result,

  output logic             io_busy,
  output logic             io_timeout
);

  // state | meaning
  // IDLE  | no op in flight; requests may be accepted
  // EXEC  | registered operands presented to the FALU
  // RESP  | result and tag held on the granted response port
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             ptr_q;
  logic             gid_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      result_q;
  logic [31:0]      in1_q, in2_q;
  logic [3:0]       ctl_q;
  logic [2:0]       rmm_q;
  logic             timeout_q;

  logic             ready0, ready1;
  logic             accept0, accept1, accept;
  logic             grant_id;
  logic             resp_ready_sel;
  logic             complete;
  logic             expire;

  // Ready is gated by reset so nothing can look accepted while reset is held.
  assign ready0   = reset && (state_q == IDLE) && (!ptr_q || !io_req1_valid);
  assign ready1   = reset && (state_q == IDLE) && ( ptr_q || !io_req0_valid);
  assign accept0  = io_req0_valid && ready0;
  assign accept1  = io_req1_valid && ready1;
  assign accept   = accept0 || accept1;
  assign grant_id = accept1;

  assign resp_ready_sel = gid_q ? io_resp1_ready : io_resp0_ready;

`ifdef FALU_ARB_TIMEOUT_EN
  logic [7:0] wait_q;

  // Expiry fires on the 255th consecutive un-consumed RESP cycle.
  assign expire = (state_q == RESP) && !resp_ready_sel && (wait_q == 8'd254);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == EXEC) begin
        wait_q <= 8'd0;
      end else if ((state_q == RESP) && !resp_ready_sel) begin
        wait_q <= wait_q + 8'd1;
      end
      if (expire) begin
        timeout_q <= 1'b1;
      end
    end
  end
`else
  assign expire    = 1'b0;
  assign timeout_q = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    complete = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready_sel || expire) begin
          state_d  = IDLE;
          complete = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Priority only flips when an op leaves RESP, not on accept.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q <= 1'b0;
    end else if (complete) begin
      ptr_q <= ~gid_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in1_q <= 32'd0;
      in2_q <= 32'd0;
      ctl_q <= 4'd0;
      rmm_q <= 3'd0;
      tag_q <= '0;
      gid_q <= 1'b0;
    end else if (accept) begin
      in1_q <= grant_id ? io_req1_input1 : io_req0_input1;
      in2_q <= grant_id ? io_req1_input2 : io_req0_input2;
      ctl_q <= grant_id ? io_req1_aluCtl : io_req0_aluCtl;
      rmm_q <= grant_id ? io_req1_rmm    : io_req0_rmm;
      tag_q <= grant_id ? io_req1_tag    : io_req0_tag;
      gid_q <= grant_id;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      result_q <= 32'd0;
    end else if (state_q == EXEC) begin
      result_q <= io_falu_result;
    end
  end

  assign io_req0_ready   = ready0;
  assign io_req1_ready   = ready1;

  assign io_resp0_valid  = (state_q == RESP) && !gid_q;
  assign io_resp1_valid  = (state_q == RESP) &&  gid_q;
  assign io_resp0_result = result_q;
  assign io_resp1_result = result_q;
  assign io_resp0_tag    = tag_q;
  assign io_resp1_tag    = tag_q;

  assign io_falu_input1  = in1_q;
  assign io_falu_input2  = in2_q;
  assign io_falu_aluCtl  = ctl_q;
  assign io_falu_rmm     = rmm_q;

  assign io_busy         = (state_q != IDLE);
  assign io_timeout      = timeout_q;

endmodule

// File: tb/tb_falu_arbiter.sv
// tb_falu_arbiter: directed + random bench for falu_arbiter with a transaction-level model
// and a stand-in FALU; define FALU_ARB_TIMEOUT_EN to also exercise the timeout path.
module tb_falu_arbiter;
  localparam int TAG_W = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [1:0]       rv;
  logic [1:0]       rr;
  logic [31:0]      a1 [2];
  logic [31:0]      a2 [2];
  logic [3:0]       ctl [2];
  logic [2:0]       rm [2];
  logic [TAG_W-1:0] tg [2];

  logic             rdy0, rdy1, v0, v1, busy, tout;
  logic [31:0]      res0, res1;
  logic [TAG_W-1:0] tag0, tag1;
  logic [31:0]      f1, f2, fres;
  logic [3:0]       fc;
  logic [2:0]       fr;

  // Stand-in FALU: only op 0xA produces a value; 1.0+1.0 is exact for the directed case.
  function automatic logic [31:0] fake_falu(logic [31:0] a, logic [31:0] b,
                                            logic [3:0] c, logic [2:0] r);
    if (c != 4'hA) return 32'd0;
    if (a == 32'h3F800000 && b == 32'h3F800000) return 32'h40000000;
    return a + {b[30:0], b[31]} + {29'd0, r};
  endfunction

  assign fres = fake_falu(f1, f2, fc, fr);

  falu_arbiter #(.TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset),
    .io_req0_valid(rv[0]), .io_req0_ready(rdy0), .io_req0_input1(a1[0]), .io_req0_input2(a2[0]),
    .io_req0_aluCtl(ctl[0]), .io_req0_rmm(rm[0]), .io_req0_tag(tg[0]),
    .io_req1_valid(rv[1]), .io_req1_ready(rdy1), .io_req1_input1(a1[1]), .io_req1_input2(a2[1]),
    .io_req1_aluCtl(ctl[1]), .io_req1_rmm(rm[1]), .io_req1_tag(tg[1]),
    .io_resp0_valid(v0), .io_resp0_ready(rr[0]), .io_resp0_result(res0), .io_resp0_tag(tag0),
    .io_resp1_valid(v1), .io_resp1_ready(rr[1]), .io_resp1_result(res1), .io_resp1_tag(tag1),
    .io_falu_input1(f1), .io_falu_input2(f2), .io_falu_aluCtl(fc), .io_falu_rmm(fr),
    .io_falu_result(fres),
    .io_busy(busy), .io_timeout(tout)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Transaction model: one op in flight, aged in cycles since accept.
  bit               m_busy;
  int               m_age, m_ptr, m_gid, m_wait;
  bit               m_timeout;
  logic [31:0]      m_f1, m_f2;
  logic [3:0]       m_fc;
  logic [2:0]       m_fr;
  logic [TAG_W-1:0] m_tag;

  int acc_log[$];
  int acc_cyc[$];

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h cycle=%0d", name, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_age = 0; m_ptr = 0; m_gid = 0; m_wait = 0; m_timeout = 0;
    m_f1 = 0; m_f2 = 0; m_fc = 0; m_fr = 0; m_tag = 0;
  endtask

  task automatic check_outputs();
    logic e_r0, e_r1, e_v0, e_v1;
    e_r0 = !m_busy && (m_ptr == 0 || !rv[1]);
    e_r1 = !m_busy && (m_ptr == 1 || !rv[0]);
    e_v0 = m_busy && m_age >= 2 && m_gid == 0;
    e_v1 = m_busy && m_age >= 2 && m_gid == 1;
    chk("busy",   32'(busy), 32'(m_busy));
    chk("ready0", 32'(rdy0), 32'(e_r0));
    chk("ready1", 32'(rdy1), 32'(e_r1));
    chk("resp0_valid", 32'(v0), 32'(e_v0));
    chk("resp1_valid", 32'(v1), 32'(e_v1));
    chk("timeout", 32'(tout), 32'(m_timeout));
    chk("falu_input1", f1, m_f1);
    chk("falu_input2", f2, m_f2);
    chk("falu_aluCtl", 32'(fc), 32'(m_fc));
    chk("falu_rmm",    32'(fr), 32'(m_fr));
    if (e_v0) begin
      chk("resp0_result", res0, fake_falu(m_f1, m_f2, m_fc, m_fr));
      chk("resp0_tag", 32'(tag0), 32'(m_tag));
    end
    if (e_v1) begin
      chk("resp1_result", res1, fake_falu(m_f1, m_f2, m_fc, m_fr));
      chk("resp1_tag", 32'(tag1), 32'(m_tag));
    end
  endtask

  task automatic model_edge();
    if (!m_busy) begin
      int g;
      g = -1;
      if (rv[m_ptr]) g = m_ptr;
      else if (rv[1 - m_ptr]) g = 1 - m_ptr;
      if (g >= 0) begin
        m_busy = 1; m_age = 1; m_gid = g;
        m_f1 = a1[g]; m_f2 = a2[g]; m_fc = ctl[g]; m_fr = rm[g]; m_tag = tg[g];
      end
    end else if (m_age == 1) begin
      m_age = 2; m_wait = 0;
    end else if (rr[m_gid]) begin
      m_busy = 0; m_ptr = 1 - m_gid;
    end else begin
`ifdef FALU_ARB_TIMEOUT_EN
      m_wait++;
      if (m_wait == 255) begin
        m_busy = 0; m_ptr = 1 - m_gid; m_timeout = 1;
      end
`endif
    end
  endtask

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic step();
    #2;
    check_outputs();
    if (rv[0] && rdy0) begin acc_log.push_back(0); acc_cyc.push_back(cyc); end
    if (rv[1] && rdy1) begin acc_log.push_back(1); acc_cyc.push_back(cyc); end
    model_edge();
    @(posedge clock);
    cyc++;
    #1;
  endtask

  task automatic pulse_reset();
    #2;
    reset = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid0", 32'(v0), 32'd0);
    chk("rst_valid1", 32'(v1), 32'd0);
    chk("rst_ready0", 32'(rdy0), 32'd0);
    chk("rst_ready1", 32'(rdy1), 32'd0);
    model_reset();
    #3;
    reset = 1'b1;
    @(posedge clock);
    cyc++;
    #1;
  endtask

  task automatic set_op(int n, logic [31:0] x, logic [31:0] y, logic [3:0] c,
                        logic [2:0] r, logic [TAG_W-1:0] t);
    a1[n] = x; a2[n] = y; ctl[n] = c; rm[n] = r; tg[n] = t;
  endtask

  initial begin
    int n_resp;
    rv = 2'b11; rr = 2'b00;
    for (int n = 0; n < 2; n++) set_op(n, 32'd0, 32'd0, 4'd0, 3'd0, '0);
    model_reset();

    // Reset values, with both valids high so ready gating is visible.
    #2;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ready0", 32'(rdy0), 32'd0);
    chk("reset_ready1", 32'(rdy1), 32'd0);
    chk("reset_valid0", 32'(v0), 32'd0);
    chk("reset_valid1", 32'(v1), 32'd0);
    chk("reset_falu_in1", f1, 32'd0);
    chk("reset_falu_ctl", 32'(fc), 32'd0);
    chk("reset_result", res0, 32'd0);
    chk("reset_tag", 32'(tag0), 32'd0);
    chk("reset_timeout", 32'(tout), 32'd0);
    rv = 2'b00;
    #6;
    reset = 1'b1;
    @(posedge clock);
    cyc++;
    #1;

    // Single op on port 0.
    set_op(0, 32'h3F800000, 32'h3F800000, 4'hA, 3'd0, 4'd3);
    rv = 2'b01; rr = 2'b11;
    step();
    rv = 2'b00;
    chk("single_exec_valid", 32'(v0), 32'd0);
    chk("single_falu_in1", f1, 32'h3F800000);
    chk("single_falu_ctl", 32'(fc), 32'hA);
    step();
    chk("single_valid0", 32'(v0), 32'd1);
    chk("single_valid1", 32'(v1), 32'd0);
    chk("single_result", res0, 32'h40000000);
    chk("single_tag", 32'(tag0), 32'd3);
    step();
    chk("single_done_busy", 32'(busy), 32'd0);

    // Contention from reset: 0,1,0,1 with one accept every 3 cycles.
    pulse_reset();
    acc_log.delete(); acc_cyc.delete();
    set_op(0, 32'h11111111, 32'h22222222, 4'hA, 3'd1, 4'd5);
    set_op(1, 32'h33333333, 32'h44444444, 4'hA, 3'd2, 4'd9);
    rv = 2'b11; rr = 2'b11;
    for (int i = 0; i < 12; i++) step();
    rv = 2'b00;
    chk("contention_accepts", 32'(acc_log.size()), 32'd4);
    for (int i = 0; i < acc_log.size() && i < 4; i++) begin
      chk("contention_order", 32'(acc_log[i]), 32'(i % 2));
      if (i > 0) chk("contention_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
    end

    // Backpressure on port 1 while port 0 waits.
    set_op(1, 32'hCAFE0001, 32'h00000123, 4'hA, 3'd4, 4'd12);
    rv = 2'b10; rr = 2'b00;
    step();
    rv = 2'b01;
    step();
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid1", 32'(v1), 32'd1);
      chk("bp_result", res1, fake_falu(32'hCAFE0001, 32'h00000123, 4'hA, 3'd4));
      chk("bp_tag", 32'(tag1), 32'd12);
      step();
    end
    rr = 2'b11;
    step();
    chk("bp_released", 32'(v1), 32'd0);
    step();
    rv = 2'b00;
    step();
    step();

    // Unsupported op returns zero with its own tag.
    set_op(0, 32'h12345678, 32'h9ABCDEF0, 4'h3, 3'd5, 4'd7);
    rv = 2'b01;
    step();
    rv = 2'b00;
    step();
    chk("unsup_valid", 32'(v0), 32'd1);
    chk("unsup_result", res0, 32'd0);
    chk("unsup_tag", 32'(tag0), 32'd7);
    step();

    // Reset in EXEC discards the op; ptr=0 behaviour afterwards.
    set_op(1, 32'h0000AAAA, 32'h0000BBBB, 4'hA, 3'd0, 4'd2);
    rv = 2'b10;
    step();
    rv = 2'b00;
    pulse_reset();
    chk("postrst_busy", 32'(busy), 32'd0);
    rv = 2'b11;
    #1;
    chk("postrst_ptr_ready0", 32'(rdy0), 32'd1);
    chk("postrst_ptr_ready1", 32'(rdy1), 32'd0);
    for (int i = 0; i < 6; i++) step();
    rv = 2'b00;
    step(); step(); step();

`ifdef FALU_ARB_TIMEOUT_EN
    pulse_reset();
    set_op(0, 32'h00000010, 32'h00000020, 4'hA, 3'd0, 4'd4);
    set_op(1, 32'h00000030, 32'h00000040, 4'hA, 3'd0, 4'd6);
    rv = 2'b01; rr = 2'b00;
    step();
    rv = 2'b10;
    step();
    n_resp = 0;
    while (v0 && n_resp < 300) begin
      step();
      n_resp++;
    end
    chk("timeout_resp_cycles", 32'(n_resp), 32'd255);
    chk("timeout_flag", 32'(tout), 32'd1);
    chk("timeout_valid0", 32'(v0), 32'd0);
    chk("timeout_grant1", 32'(rdy1), 32'd1);
    rr = 2'b11;
    step();
    rv = 2'b00;
    for (int i = 0; i < 4; i++) step();
    chk("timeout_sticky", 32'(tout), 32'd1);
`else
    n_resp = 0;
    chk("timeout_tied_low", 32'(tout), 32'(n_resp));
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      for (int n = 0; n < 2; n++) begin
        rv[n] = ($urandom_range(0, 3) != 0);
        rr[n] = ($urandom_range(0, 3) != 0);
        set_op(n, $urandom, $urandom,
               ($urandom_range(0, 1) != 0) ? 4'hA : 4'($urandom_range(0, 15)),
               3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/falu_arbiter.md
# falu_arbiter

Two-requester arbiter and sequencer for the shared combinational FALU datapath. It accepts operations from two issue ports over valid/ready handshakes and picks between them round-robin. It registers the operands onto the FALU inputs, captures the FALU result one cycle later, and returns that result with the requester's tag on the matching response port. It sits between the issue stage and the FALU instance.

## Interface
- TAG_W, 4, width of the request/response tag carried through unchanged
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- io_reqN_valid  in  1  request valid, N = 0,1
- io_reqN_ready  out  1  request accepted this cycle when valid&ready
- io_reqN_input1 / io_reqN_input2  in  32  operands
- io_reqN_aluCtl  in  4  FALU op select
- io_reqN_rmm  in  3  rounding mode
- io_reqN_tag  in  TAG_W  requester tag
- io_respN_valid  out  1  result valid for requester N
- io_respN_ready  in  1  requester N consumes result
- io_respN_result  out  32  registered FALU result
- io_respN_tag  out  TAG_W  tag of the completed op
- io_falu_input1 / io_falu_input2  out  32  registered operands to FALU
- io_falu_aluCtl  out  4  registered op to FALU
- io_falu_rmm  out  3  registered rounding mode to FALU
- io_falu_result  in  32  FALU combinational result
- io_busy  out  1  state != IDLE
- io_timeout  out  1  sticky response-timeout flag (see Configuration)

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE: grant = ptr if io_req[ptr]_valid, else the other requester if it is valid.
  - io_reqN_ready = (state==IDLE) && (ptr==N || !io_req[other]_valid). Ready may depend on the other port's valid, never on its own.
  - On accept: latch input1, input2, aluCtl, rmm into the io_falu_* registers; latch tag and grant id; go to EXEC.
- EXEC: the FALU sees stable registered operands. At the end of the cycle, capture io_falu_result into the result register; go to RESP.
- RESP: assert io_resp[gid]_valid with the result and tag; the other response port stays low.
  - On io_resp[gid]_ready: go to IDLE and set ptr = ~gid.
  - Result and tag stay stable until consumed.
- aluCtl is not filtered. An unsupported op returns whatever the FALU produces (0 for ops other than 0xA).
- io_falu_* hold their last values between ops; no toggling while idle.
- Reset values: io_falu_* = 0, result = 0, tag = 0, ptr = 0, all ready/valid = 0, io_busy = 0, io_timeout = 0.

## Timing
- Accept in cycle T → io_falu_* valid from T+1 → io_respN_valid high from T+2.
- Minimum 3 cycles per op. There is no overlap: a new request is never accepted in RESP, even in the cycle the response fires.
- Response backpressure holds RESP indefinitely (unless the timeout feature is enabled).
- Both requesters valid in IDLE: ptr wins and the loser waits. Priority alternates after every completion, not after every accept.
- A requester dropping valid before accept is legal; nothing is latched.
- Reset asserted mid-op (EXEC or RESP): immediate return to IDLE. The in-flight op is discarded, resp valids drop asynchronously, and no response is produced after release.

## Configuration
- FALU_ARB_TIMEOUT_EN defined: an 8-bit counter clears on entry to RESP and increments each RESP cycle without resp_ready.
  - When it reaches 255, the result is dropped, the FSM goes to IDLE, ptr = ~gid, and io_timeout sets sticky (cleared only by reset).
- Not defined: no counter, io_timeout tied 0, RESP waits forever.

## Test plan
- Single op: req0 input1=0x3F800000, input2=0x3F800000, aluCtl=0xA, tag=3 → resp0_valid at T+2, result=0x40000000, tag=3; resp1_valid stays 0.
- Contention: req0 and req1 valid simultaneously from reset, resp ready held 1 → grants in order 0,1,0,1; each response carries its own tag; one accept per 3 cycles.
- Backpressure: resp1_ready=0 for 10 cycles → resp1_valid and result stable throughout; io_reqN_ready=0 throughout; completes one cycle after ready rises.
- Unsupported op: aluCtl=0x3 with any operands → result=0x00000000 returned with the correct tag.
- Reset mid-op: assert reset in EXEC → io_busy=0 and all valids 0 immediately; after release the next request sees ptr=0 behaviour and no stale response appears.
- With FALU_ARB_TIMEOUT_EN: resp0_ready held 0 → after 255 RESP cycles resp0_valid drops, io_timeout=1 and stays 1, and a pending req1 is granted next.
